// File: rtl/alu_exec_pipe.sv
// alu_exec_pipe: two-stage valid/ready ALU; S1 captures operands/control, S2 holds the result and flags
module alu_exec_pipe #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       alucontrol,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             illegal
);
  localparam int M = WIDTH - 1;
  logic             s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
  logic [2:0]       ctl_q, ctl_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, result_q, result_d;
  logic [WIDTH-1:0] add_r, sub_r, alu_r;
  logic             ovf_q, ovf_d, ill_q, ill_d, ovf_r, ill_r;
  logic             s2_free, s1_adv, accept, deliver;
  always_comb begin
    s2_free    = !s2_valid_q || out_ready;
    s1_adv     = s1_valid_q && s2_free;
    in_ready   = !s1_valid_q || s1_adv;
    accept     = in_valid && in_ready;
    deliver    = s2_valid_q && out_ready;
    add_r      = a_q + b_q;
    sub_r      = a_q - b_q;
    ill_r      = ctl_q[2:1] == 2'b10;
    alu_r      = ctl_q == 3'b010 ? add_r :
                 ctl_q == 3'b110 ? sub_r :
                 ctl_q == 3'b000 ? a_q & b_q :
                 ctl_q == 3'b001 ? a_q | b_q :
                 ctl_q == 3'b011 ? ~(a_q | b_q) :
                 ctl_q == 3'b111 ? {{M{1'b0}}, $signed(a_q) < $signed(b_q)} : '0;
    ovf_r      = ctl_q == 3'b010 ? (a_q[M] == b_q[M]) && (add_r[M] != a_q[M]) :
                 ctl_q == 3'b110 ? (a_q[M] != b_q[M]) && (sub_r[M] != a_q[M]) : 1'b0;
    s1_valid_d = accept ? 1'b1 : s1_adv ? 1'b0 : s1_valid_q;
    ctl_d      = accept ? alucontrol : ctl_q;
    a_d        = accept ? srca : a_q;
    b_d        = accept ? srcb : b_q;
    s2_valid_d = s1_adv ? 1'b1 : deliver ? 1'b0 : s2_valid_q;
    result_d   = s1_adv ? alu_r : result_q;
    ovf_d      = s1_adv ? ovf_r : ovf_q;
    ill_d      = s1_adv ? ill_r : ill_q;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      ctl_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      result_q   <= '0;
      ovf_q      <= 1'b0;
      ill_q      <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      ctl_q      <= ctl_d;
      a_q        <= a_d;
      b_q        <= b_d;
      result_q   <= result_d;
      ovf_q      <= ovf_d;
      ill_q      <= ill_d;
    end
  end
  assign out_valid = s2_valid_q;
  assign result    = result_q;
  assign zero      = s2_valid_q && (result_q == '0);
  assign overflow  = ovf_q;
  assign illegal   = ill_q;
endmodule

// File: tb/tb_alu_exec_pipe.sv
// tb_alu_exec_pipe: directed self-checking bench for alu_exec_pipe
module tb_alu_exec_pipe;
  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  alucontrol = 3'b000;
  logic [31:0] srca = '0;
  logic [31:0] srcb = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic        zero, overflow, illegal;
  int          checks = 0;
  int          errors = 0;
  alu_exec_pipe #(.WIDTH(32)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .alucontrol(alucontrol), .srca(srca), .srcb(srcb), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .zero(zero), .overflow(overflow),
    .illegal(illegal)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic send_one(input string tag, input logic [2:0] c, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] r, input logic z, input logic o, input logic il);
    @(negedge clk);
    in_valid = 1'b1; alucontrol = c; srca = a; srcb = b; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk({tag, "_early"}, {31'b0, out_valid}, 32'd0);
    @(negedge clk);
    chk({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
    chk({tag, "_result"}, result, r);
    chk({tag, "_zero"}, {31'b0, zero}, {31'b0, z});
    chk({tag, "_ovf"}, {31'b0, overflow}, {31'b0, o});
    chk({tag, "_ill"}, {31'b0, illegal}, {31'b0, il});
  endtask
  logic [2:0]  bctl [4] = '{3'b000, 3'b001, 3'b010, 3'b110};
  logic [31:0] ba   [4] = '{32'h0000_F0F0, 32'h0000_F0F0, 32'd10, 32'd3};
  logic [31:0] bb   [4] = '{32'h0000_FF00, 32'h0000_0F00, 32'd20, 32'd5};
  logic [31:0] bexp [4] = '{32'h0000_F000, 32'h0000_FFF0, 32'd30, 32'hFFFF_FFFE};
  initial begin
    int sent, got;
    logic [31:0] held;
    logic stalled;
    #3 reset_n = 1'b0;
    #1;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_zero", {31'b0, zero}, 32'd0);
    chk("rst_ovf", {31'b0, overflow}, 32'd0);
    chk("rst_ill", {31'b0, illegal}, 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    #1 chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    send_one("add_ovf", 3'b010, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    send_one("sub_zero", 3'b110, 32'd5, 32'd5, 32'd0, 1'b1, 1'b0, 1'b0);
    send_one("sub_ovf", 3'b110, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0);
    send_one("slt", 3'b111, 32'hFFFF_FFFF, 32'h0000_0001, 32'd1, 1'b0, 1'b0, 1'b0);
    send_one("slt_false", 3'b111, 32'h0000_0001, 32'hFFFF_FFFF, 32'd0, 1'b1, 1'b0, 1'b0);
    send_one("nor", 3'b011, 32'd0, 32'd0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
    send_one("illegal", 3'b101, 32'h1234_5678, 32'h1, 32'd0, 1'b1, 1'b0, 1'b1);
    send_one("add_after_ill", 3'b010, 32'd2, 32'd3, 32'd5, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("drained", {31'b0, out_valid}, 32'd0);
    sent = 0; got = 0; stalled = 1'b0; held = '0;
    for (int k = 0; k < 30 && got < 4; k++) begin
      @(negedge clk);
      out_ready = !(k inside {2, 3, 4});
      in_valid = sent < 4;
      if (sent < 4) begin
        alucontrol = bctl[sent]; srca = ba[sent]; srcb = bb[sent];
      end
      #1;
      if (k == 2) chk("b2b_in_ready_drop", {31'b0, in_ready}, 32'd0);
      if (stalled) begin
        chk($sformatf("b2b_stall_valid_%0d", k), {31'b0, out_valid}, 32'd1);
        chk($sformatf("b2b_stall_hold_%0d", k), result, held);
      end
      stalled = out_valid && !out_ready;
      held = result;
      if (in_valid && in_ready) sent++;
      if (out_valid && out_ready) begin
        chk($sformatf("b2b_res_%0d", got), result, bexp[got]);
        got++;
      end
    end
    in_valid = 1'b0;
    chk("b2b_sent", sent, 32'd4);
    chk("b2b_got", got, 32'd4);
    @(negedge clk);
    #1 chk("b2b_no_dup", {31'b0, out_valid}, 32'd0);
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; alucontrol = 3'b010; srca = 32'd1; srcb = 32'd1;
    @(negedge clk);
    srca = 32'd2;
    @(negedge clk);
    in_valid = 1'b0;
    #1 chk("full_in_ready", {31'b0, in_ready}, 32'd0);
    chk("full_out_valid", {31'b0, out_valid}, 32'd1);
    #1 reset_n = 1'b0;
    #1;
    chk("async_out_valid", {31'b0, out_valid}, 32'd0);
    chk("async_result", result, 32'd0);
    @(negedge clk);
    reset_n = 1'b1; out_ready = 1'b1;
    #1 chk("rel_in_ready", {31'b0, in_ready}, 32'd1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("rel_no_pulse_%0d", k), {31'b0, out_valid}, 32'd0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
